conv_encoder: RTL and testbench
===============================

Name: conv_encoder

Overview:
- Rate-1/2 feed-forward convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder (BMU/PMU/TBU chain).
- Accepts a serial bit stream with a valid/ready handshake and emits 2-bit coded symbols with a valid/ready handshake.
- Appends K-1 zero tail bits per frame so the decoder trellis always terminates in state 0.
- Sits in front of the channel model / decoder input in the top-level loopback bench.

Parameters:
- K, 3, constraint length; the shift register holds K-1 bits. Default 3 gives the 4-state trellis the decoder uses.
- G0, 3'b111 (octal 7), generator polynomial for coded bit c0. Width K; MSB taps the current input.
- G1, 3'b101 (octal 5), generator polynomial for coded bit c1. Width K.
- MAX_FRAME, 64, maximum number of data bits per frame before a forced termination.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  data_i is valid this cycle
- data_i  in  1  information bit
- last_i  in  1  this bit is the final data bit of the frame (qualified by valid_i)
- ready_o  out  1  encoder accepts a data bit this cycle
- sym_o  out  2  coded symbol; [1]=c0, [0]=c1
- sym_mask_o  out  2  per-bit transmit mask; [1] qualifies c0, [0] qualifies c1
- sym_valid_o  out  1  sym_o/sym_mask_o/sym_last_o valid
- sym_ready_i  in  1  downstream accepts the symbol
- sym_last_o  out  1  final tail symbol of the frame
- busy_o  out  1  frame in progress (state is not IDLE)
- frame_err_o  out  1  one-cycle pulse: MAX_FRAME was reached without last_i

Behaviour:
- Reset (async assert, sync deassert use): FSM=IDLE, shift register sr=0, frame counter=0, output register empty. All outputs 0 except sym_mask_o=2'b11. ready_o rises in the first cycle after reset release.
- Coding: with sr={d[n-1],...,d[n-K+1]} and v={d_in,sr}, c0=^(v&G0) and c1=^(v&G1). With defaults, c0=d^d1^d2 and c1=d^d2.
- Output register: single-entry. It loads when empty, or when it is being drained in the same cycle (sym_valid_o && sym_ready_i).
- sym_valid_o, sym_o and sym_last_o stay stable until accepted.
- ready_o = (state is IDLE or DATA) AND output register loadable.
- Latency: a bit accepted at edge N appears on sym_o after edge N, one cycle later.
- FSM:
  - IDLE: the first accepted bit moves to DATA and is encoded. If it also carries last_i, go to TAIL.
  - DATA: each accepted bit is encoded and increments the counter. last_i on the accepted bit moves to TAIL.
  - Forced termination: if the counter reaches MAX_FRAME on an accepted bit without last_i, that bit is treated as last, frame_err_o pulses one cycle, and the FSM moves to TAIL.
  - TAIL: ready_o=0. Emit K-1 symbols with d_in=0, each loaded only when the output register is loadable. The final one sets sym_last_o=1.
  - After the last tail symbol is loaded, go to IDLE with sr=0 and counter=0. busy_o stays 1 until that symbol is accepted downstream.
- Backpressure: while sym_ready_i=0 and the register is full, there is no state, sr or counter change, and no bit is dropped.
- valid_i while ready_o=0 is ignored; the upstream holds.
- Reset mid-frame: immediate abort. Partial frame is discarded, no tail is emitted, and the encoder restarts clean.

Optional Feature:
- Macro: CONV_ENC_PUNCTURE_EN.
- When defined: rate-2/3 puncturing with period 2 over every emitted symbol, including tail symbols.
  - Symbols at even index: mask 2'b11.
  - Symbols at odd index: mask 2'b10 (c1 dropped; sym_o[0] driven 0).
  - The phase counter resets at frame start.
- When undefined: sym_mask_o is constant 2'b11 and no phase logic is built.

Decomposition:
- Shared package conv_pkg holds:
  - K, G0 and G1 defaults (also used by the decoder BMU for expected-branch generation);
  - state typedef enum {IDLE, DATA, TAIL};
  - symbol typedef logic [1:0].
- Sub-module conv_enc_core: combinational generator function for (d_in, sr) -> {c0,c1}. The decoder branch-metric unit reuses it so encoder and decoder trellises cannot diverge.

Test Plan:
- Basic frame: reset, send 1,0,1,1 with last_i on the 4th, sym_ready_i=1 → symbols 11,10,00,01,01,11. sym_last_o only on the 6th. busy_o falls after the 6th is accepted.
- Backpressure: same frame, sym_ready_i toggling 1,0,0,1,… → identical symbol sequence. sym_o stable while stalled. ready_o=0 whenever the register is full and not draining.
- Forced termination: MAX_FRAME=8, stream 10 bits with no last_i →
  - 8 data symbols followed by 2 tail symbols;
  - frame_err_o pulses once, in the cycle after the 8th bit is accepted;
  - the 9th bit is not accepted until IDLE.
- Reset mid-frame: assert rst_n=0 after the 2nd symbol of a frame → all outputs 0 and sr=0. A new frame 1,0,1,1 then yields 11,10,00,01,01,11 again.
- Puncture (CONV_ENC_PUNCTURE_EN defined): basic frame → masks 11,10,11,10,11,10. sym_o[0]=0 on the odd symbols.
- Loopback: 32 random bits → conv_encoder → Viterbi decoder, error-free channel → decoded bits equal the input bits.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and the Viterbi decoder.
// Holds the default trellis (K=3, G0=7, G1=5), the control state type and the symbol type.
package conv_pkg;

  localparam int                 K_DEF         = 3;
  localparam logic [K_DEF-1:0]   G0_DEF        = 3'b111;
  localparam logic [K_DEF-1:0]   G1_DEF        = 3'b101;
  localparam int                 MAX_FRAME_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // [1] = c0, [0] = c1
  typedef logic [1:0] sym_t;

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-stream input and coded-symbol output bundle of conv_encoder.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a source holds its payload stable while valid is high and ready is low, and ready never waits on valid.
interface conv_encoder_if;
  import conv_pkg::*;

  logic valid_i;
  logic data_i;
  logic last_i;
  logic ready_o;
  sym_t sym_o;
  sym_t sym_mask_o;
  logic sym_valid_o;
  logic sym_ready_i;
  logic sym_last_o;
  logic busy_o;
  logic frame_err_o;

  modport slave (
    input  valid_i, data_i, last_i, sym_ready_i,
    output ready_o, sym_o, sym_mask_o, sym_valid_o, sym_last_o, busy_o, frame_err_o
  );

  modport master (
    output valid_i, data_i, last_i, sym_ready_i,
    input  ready_o, sym_o, sym_mask_o, sym_valid_o, sym_last_o, busy_o, frame_err_o
  );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational generator: (d_in, sr) -> {c0, c1}. Shared with the decoder branch-metric unit
// so both ends of the link are built from the same trellis.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int             K  = K_DEF,
  parameter logic [K-1:0]   G0 = G0_DEF,
  parameter logic [K-1:0]   G1 = G1_DEF
) (
  input  logic         d_in,
  input  logic [K-2:0] sr,
  output sym_t         sym
);

  logic [K-1:0] v;

  always_comb begin
    v   = {d_in, sr};
    sym = {^(v & G0), ^(v & G1)};
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with K-1 zero-tail termination per frame.
// Optional rate-2/3 puncturing (period 2) is built when CONV_ENC_PUNCTURE_EN is defined.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int           K         = K_DEF,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF,
  parameter int           MAX_FRAME = MAX_FRAME_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_encoder_if.slave        enc,
  output state_t               dbg_state_o,
  output logic [K-2:0]         dbg_sr_o
);

  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_FRAME);
  localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

  state_t          state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]   tail_q, tail_d;
  logic            init_q;
  logic            full_q, full_d;
  sym_t            sym_q, sym_d;
  logic            last_q, last_d;
  logic            err_q, err_d;

  logic            loadable;
  logic            ready;
  logic            accept;
  logic            tail_load;
  logic            load;
  logic            core_d;
  logic [K-1:0]    shift_v;
  sym_t            code;
  sym_t            load_sym;

  conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .d_in (core_d),
    .sr   (sr_q),
    .sym  (code)
  );

  always_comb begin
    loadable  = !full_q || enc.sym_ready_i;
    ready     = init_q && loadable && (state_q == IDLE || state_q == DATA);
    accept    = ready && enc.valid_i;
    tail_load = (state_q == TAIL) && loadable;
    load      = accept || tail_load;
    core_d    = accept && enc.data_i;
    shift_v   = {core_d, sr_q};
  end

`ifdef CONV_ENC_PUNCTURE_EN
  logic phase_q, phase_d, phase_use;
  sym_t mask_q, mask_d, load_mask;

  // The first data bit of a frame always lands on phase 0, so each frame starts unpunctured.
  always_comb begin
    phase_use = (accept && state_q == IDLE) ? 1'b0 : phase_q;
    load_mask = phase_use ? 2'b10 : 2'b11;
    load_sym  = code & load_mask;
    phase_d   = phase_q;
    mask_d    = mask_q;
    if (load) begin
      phase_d = ~phase_use;
      mask_d  = load_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      mask_q  <= 2'b11;
    end else begin
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign enc.sym_mask_o = mask_q;
`else
  assign load_sym       = code;
  assign enc.sym_mask_o = 2'b11;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    full_d  = full_q;
    sym_d   = sym_q;
    last_d  = last_q;
    err_d   = 1'b0;
    cnt_inc = cnt_q + 1'b1;

    if (full_q && enc.sym_ready_i) full_d = 1'b0;

    if (accept) begin
      full_d = 1'b1;
      sym_d  = load_sym;
      last_d = 1'b0;
      sr_d   = shift_v[K-1:1];
      cnt_d  = cnt_inc;
      tail_d = '0;
      if (enc.last_i) begin
        state_d = TAIL;
      end else if (cnt_inc == CNT_MAX) begin
        // Frame overran without last_i: close it here and flag it.
        state_d = TAIL;
        err_d   = 1'b1;
      end else begin
        state_d = DATA;
      end
    end else if (tail_load) begin
      full_d = 1'b1;
      sym_d  = load_sym;
      sr_d   = shift_v[K-1:1];
      tail_d = tail_q + 1'b1;
      last_d = 1'b0;
      if (tail_q == TAIL_LAST) begin
        last_d  = 1'b1;
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      init_q  <= 1'b0;
      full_q  <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      init_q  <= 1'b1;
      full_q  <= full_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // busy covers the window where the closing tail symbol still waits downstream.
  assign enc.ready_o     = ready;
  assign enc.sym_o       = sym_q;
  assign enc.sym_valid_o = full_q;
  assign enc.sym_last_o  = last_q;
  assign enc.busy_o      = (state_q != IDLE) || (full_q && last_q);
  assign enc.frame_err_o = err_q;
  assign dbg_state_o     = state_q;
  assign dbg_sr_o        = sr_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: reset, basic frame, backpressure, forced termination, reset mid-frame.
// Expected masks follow CONV_ENC_PUNCTURE_EN when the bench is built with it.
module tb_conv_encoder;
  import conv_pkg::*;

`ifdef CONV_ENC_PUNCTURE_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] mask;
    logic       last;
  } obs_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  logic [1:0] dbg_sr;

  int checks = 0;
  int errors = 0;

  obs_t got_q[$];
  logic [1:0] exp_q[$];
  bit   bp_en = 1'b0;
  int   bp_idx = 0;
  int   stall_viol = 0;
  int   ready_viol = 0;
  int   tail_accept_viol = 0;
  int   stall_cycles = 0;
  int   err_pulses = 0;

  conv_encoder_if bus ();

  conv_encoder #(.MAX_FRAME(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc         (bus),
    .dbg_state_o (dbg_state),
    .dbg_sr_o    (dbg_sr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic reset_dut();
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    bus.last_i  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    stall_viol = 0; ready_viol = 0; tail_accept_viol = 0;
    stall_cycles = 0; err_pulses = 0;
  endtask

  // ---------------- sym_ready driver (pattern 1,0,0,1 under backpressure) ----------------
  initial begin
    bus.sym_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.sym_ready_i = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
        bp_idx++;
      end else begin
        bus.sym_ready_i = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_stall;
    obs_t prev_obs, cur;
    prev_stall = 1'b0;
    prev_obs   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{sym: bus.sym_o, mask: bus.sym_mask_o, last: bus.sym_last_o};
        if (prev_stall && (!bus.sym_valid_o || cur != prev_obs)) stall_viol++;
        if (bus.ready_o && bus.sym_valid_o && !bus.sym_ready_i) ready_viol++;
        if (bus.valid_i && bus.ready_o && dbg_state == TAIL) tail_accept_viol++;
        if (bus.frame_err_o) err_pulses++;
        if (bus.sym_valid_o && !bus.sym_ready_i) stall_cycles++;
        if (bus.sym_valid_o && bus.sym_ready_i) got_q.push_back(cur);
        prev_stall = bus.sym_valid_o && !bus.sym_ready_i;
        prev_obs   = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.last_i  = l;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_bit_timeout: bit not accepted within 200 cycles (got ready_o=%0b, need 1)", bus.ready_o);
    end
  endtask

  task automatic wait_syms(input int n);
    for (int c = 0; c < 500 && got_q.size() < n; c++) @(negedge clk);
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_syms_timeout: got %0d symbols, need %0d", got_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_basic_frame();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
  endtask

  task automatic load_basic_exp();
    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.valid_i = 1'b0; bus.data_i = 1'b0; bus.last_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sym_valid_o !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b need 0", bus.sym_valid_o); end
    checks++; if (bus.sym_o !== 2'b00) begin errors++; $display("FAIL reset_sym: got %b need 00", bus.sym_o); end
    checks++; if (bus.sym_mask_o !== 2'b11) begin errors++; $display("FAIL reset_mask: got %b need 11", bus.sym_mask_o); end
    checks++; if (bus.sym_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b need 0", bus.sym_last_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", bus.busy_o); end
    checks++; if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b need 0", bus.frame_err_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b need 0", bus.ready_o); end
    checks++; if (dbg_sr !== 2'b00) begin errors++; $display("FAIL reset_sr: got %b need 00", dbg_sr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d need %0d", dbg_state, IDLE); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b need 0", bus.ready_o); end
    @(posedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL release_ready_rise: got %b need 1", bus.ready_o); end
  endtask

  task automatic test_basic_frame();
    logic [1:0] em, es;
    reset_dut();
    load_basic_exp();
    send_bit(1'b1, 1'b0);
    checks++; if (bus.sym_valid_o !== 1'b1 || bus.sym_o !== 2'b11) begin errors++; $display("FAIL basic_latency: got valid=%b sym=%b need valid=1 sym=11", bus.sym_valid_o, bus.sym_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_in_frame: got %b need 1", bus.busy_o); end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    wait_syms(6);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL basic_count: got %0d need 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      em = (PUNCT && (i % 2 == 1)) ? 2'b10 : 2'b11;
      es = exp_q[i] & em;
      checks++; if (got_q[i].sym !== es) begin errors++; $display("FAIL basic_sym[%0d]: got %b need %b", i, got_q[i].sym, es); end
      checks++; if (got_q[i].mask !== em) begin errors++; $display("FAIL basic_mask[%0d]: got %b need %b", i, got_q[i].mask, em); end
      checks++; if (got_q[i].last !== (i == 5)) begin errors++; $display("FAIL basic_last[%0d]: got %b need %b", i, got_q[i].last, (i == 5)); end
    end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b need 0", bus.busy_o); end
    checks++; if (bus.sym_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_end: got %b need 0", bus.sym_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [1:0] em, es;
    reset_dut();
    load_basic_exp();
    bp_idx = 0;
    bp_en  = 1'b1;
    send_basic_frame();
    wait_syms(6);
    bp_en = 1'b0;
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d need 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      em = (PUNCT && (i % 2 == 1)) ? 2'b10 : 2'b11;
      es = exp_q[i] & em;
      checks++; if (got_q[i].sym !== es) begin errors++; $display("FAIL bp_sym[%0d]: got %b need %b", i, got_q[i].sym, es); end
      checks++; if (got_q[i].last !== (i == 5)) begin errors++; $display("FAIL bp_last[%0d]: got %b need %b", i, got_q[i].last, (i == 5)); end
    end
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL bp_stalls: got %0d stall cycles, need >0", stall_cycles); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalled cycles, need 0", stall_viol); end
    checks++; if (ready_viol != 0) begin errors++; $display("FAIL bp_ready: got %0d cycles ready_o=1 while full and stalled, need 0", ready_viol); end
  endtask

  task automatic test_forced_termination();
    logic [9:0] fbits;
    logic [1:0] em, es;
    reset_dut();
    fbits = 10'b11_0100_1011;  // bit i = fbits[i]: 1,1,0,1,0,0,1,0,1,1
    exp_q = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 8; i++) send_bit(fbits[i], 1'b0);
    checks++; if (bus.frame_err_o !== 1'b1) begin errors++; $display("FAIL forced_err_pulse: got %b need 1", bus.frame_err_o); end
    checks++; if (dbg_state !== TAIL) begin errors++; $display("FAIL forced_state_tail: got %0d need %0d", dbg_state, TAIL); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL forced_ready_tail: got %b need 0", bus.ready_o); end
    @(posedge clk);
    #1;
    checks++; if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL forced_err_width: got %b need 0", bus.frame_err_o); end
    send_bit(fbits[8], 1'b0);
    checks++; if (dbg_state !== DATA || dbg_sr !== 2'b10) begin errors++; $display("FAIL forced_new_frame: got state=%0d sr=%b need state=%0d sr=10", dbg_state, dbg_sr, DATA); end
    wait_syms(10);
    for (int i = 0; i < 10; i++) begin
      em = (PUNCT && (i % 2 == 1)) ? 2'b10 : 2'b11;
      es = exp_q[i] & em;
      checks++; if (got_q[i].sym !== es) begin errors++; $display("FAIL forced_sym[%0d]: got %b need %b", i, got_q[i].sym, es); end
      checks++; if (got_q[i].last !== (i == 9)) begin errors++; $display("FAIL forced_last[%0d]: got %b need %b", i, got_q[i].last, (i == 9)); end
    end
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL forced_err_count: got %0d pulses need 1", err_pulses); end
    checks++; if (tail_accept_viol != 0) begin errors++; $display("FAIL forced_tail_accept: got %0d acceptances in TAIL need 0", tail_accept_viol); end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] em, es;
    reset_dut();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_syms(2);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sym_valid_o !== 1'b0 || bus.sym_o !== 2'b00 || bus.sym_last_o !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got valid=%b sym=%b last=%b need 0,00,0", bus.sym_valid_o, bus.sym_o, bus.sym_last_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: got busy=%b ready=%b err=%b need 0,0,0", bus.busy_o, bus.ready_o, bus.frame_err_o); end
    checks++; if (dbg_sr !== 2'b00) begin errors++; $display("FAIL mid_reset_sr: got %b need 00", dbg_sr); end
    checks++; if (bus.sym_mask_o !== 2'b11) begin errors++; $display("FAIL mid_reset_mask: got %b need 11", bus.sym_mask_o); end
    reset_dut();
    load_basic_exp();
    send_basic_frame();
    wait_syms(6);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL mid_count: got %0d need 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      em = (PUNCT && (i % 2 == 1)) ? 2'b10 : 2'b11;
      es = exp_q[i] & em;
      checks++; if (got_q[i].sym !== es) begin errors++; $display("FAIL mid_sym[%0d]: got %b need %b", i, got_q[i].sym, es); end
      checks++; if (got_q[i].last !== (i == 5)) begin errors++; $display("FAIL mid_last[%0d]: got %b need %b", i, got_q[i].last, (i == 5)); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_forced_termination();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
